// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage iterative multiply/divide unit owning architectural HI/LO.
// Decodes SPECIAL (opcode 0) MFHI/MTHI/MFLO/MTLO/MULT/MULTU/DIV/DIVU directly from ID/EX.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           kill the instruction currently in EX
//   opcode, func    instruction fields from ID/EX
//   rs_data,rt_data forwarded source operands
//   stall           hold IF/ID and ID/EX while a HI/LO access waits on a running op
//   busy            iterative op in flight
//   hi, lo          architectural HI/LO
//   mf_data         HI for MFHI, LO for MFLO, otherwise zero
module ex_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_data
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] prod;       // multiply: {partial sum, remaining multiplier bits}
    logic [WIDTH-1:0]   rem;        // divide: partial remainder
    logic [WIDTH-1:0]   quo;        // divide: dividend bits shifting out, quotient bits in
    logic [WIDTH-1:0]   opb;        // multiplicand or divisor magnitude
    logic               is_div;
    logic               neg_q;      // product/quotient must be negated
    logic               neg_r;      // remainder takes negative dividend sign
    logic               div_zero;

    logic is_r, mfhi, mthi, mflo, mtlo, mul_s, mul_u, div_s, div_u;
    logic sign_op, muldiv_op, hilo_op, issue, last;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     shifted, diff;
    logic               ge;
    logic [2*WIDTH-1:0] prod_fix;

    assign is_r  = (opcode == 6'h00);
    assign mfhi  = is_r && (func == 6'h10);
    assign mthi  = is_r && (func == 6'h11);
    assign mflo  = is_r && (func == 6'h12);
    assign mtlo  = is_r && (func == 6'h13);
    assign mul_s = is_r && (func == 6'h18);
    assign mul_u = is_r && (func == 6'h19);
    assign div_s = is_r && (func == 6'h1A);
    assign div_u = is_r && (func == 6'h1B);

    assign sign_op   = mul_s | div_s;
    assign muldiv_op = mul_s | mul_u | div_s | div_u;
    assign hilo_op   = mfhi | mthi | mflo | mtlo | muldiv_op;

    assign stall   = busy & hilo_op & ~flush;
    assign issue   = (state == IDLE) & hilo_op & ~flush;
    assign mf_data = mfhi ? hi : (mflo ? lo : '0);

    assign abs_a = (sign_op && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    assign abs_b = (sign_op && rt_data[WIDTH-1]) ? -rt_data : rt_data;

    assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opb} : '0);

    // Partial remainder is always below the divisor, so bit WIDTH of the trial
    // difference is exactly the borrow: clear means the subtraction is kept.
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, opb};
    assign ge      = ~diff[WIDTH];

    assign prod_fix = neg_q ? -prod : prod;
    assign last     = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            count    <= '0;
            prod     <= '0;
            rem      <= '0;
            quo      <= '0;
            opb      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        if (mthi) hi <= rs_data;
                        if (mtlo) lo <= rs_data;
                        if (muldiv_op) begin
                            opb      <= abs_b;
                            count    <= '0;
                            busy     <= 1'b1;
                            neg_q    <= sign_op && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                            neg_r    <= div_s && rs_data[WIDTH-1];
                            div_zero <= (rt_data == '0);
                            if (mul_s || mul_u) begin
                                prod   <= {{WIDTH{1'b0}}, abs_a};
                                is_div <= 1'b0;
                                state  <= MUL;
                            end else begin
                                quo    <= abs_a;
                                rem    <= '0;
                                is_div <= 1'b1;
                                state  <= DIV;
                            end
                        end
                    end
                end
                MUL: begin
                    prod  <= {mul_sum, prod[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (last) state <= FIX;
                end
                DIV: begin
                    rem   <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo   <= {quo[WIDTH-2:0], ge};
                    count <= count + 1'b1;
                    if (last) state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (is_div) begin
                        // Zero divisor: quotient forced to all ones; remainder with the
                        // dividend sign reproduces rs unchanged.
                        lo <= div_zero ? '1 : (neg_q ? -quo : quo);
                        hi <= neg_r ? -rem : rem;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: self-checking bench for ex_muldiv (WIDTH=32).
// Directed table of multiply/divide results, hand sequences for stall/flush/reset
// behaviour, and randomized operations checked against an arithmetic reference model.
module tb_ex_muldiv;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [5:0]  opcode, func;
    logic [31:0] rs_data, rt_data;
    logic        stall, busy;
    logic [31:0] hi, lo, mf_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .opcode(opcode), .func(func),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .busy(busy),
        .hi(hi), .lo(lo), .mf_data(mf_data)
    );

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a, b, hi, lo;
        string       name;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        opcode = 6'h00;
        func   = F_ADD;
        flush  = 1'b0;
    endtask

    // Called just after the issue edge; counts cycles busy stays high.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            tick();
        end
    endtask

    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int cycles);
        opcode  = 6'h00;
        func    = f;
        rs_data = a;
        rt_data = b;
        flush   = 1'b0;
        tick();
        nop();
        wait_idle(cycles);
    endtask

    // Architectural result {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (f)
            F_MULT:  r = 64'(sa * sb);
            F_MULTU: r = {32'h0, a} * {32'h0, b};
            F_DIV: begin
                if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
                else begin
                    r[31:0]  = 32'(sa / sb);
                    r[63:32] = 32'(sa % sb);
                end
            end
            F_DIVU: begin
                if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] sp[5];
        sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFF_FFFF;
        sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
        if ($urandom_range(3) == 0) return sp[$urandom_range(4)];
        if ($urandom_range(1) == 0) return 32'($urandom_range(1000));
        return $urandom;
    endfunction

    initial begin
        int          cyc;
        logic [63:0] exp;
        logic [5:0]  ops[4];

        tbl[0]  = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
        tbl[1]  = '{F_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m3x7"};
        tbl[2]  = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2"};
        tbl[3]  = '{F_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, "divu_by0"};
        tbl[4]  = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf"};
        tbl[5]  = '{F_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_neg_by0"};
        tbl[6]  = '{F_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "divu_100d7"};
        tbl[7]  = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minmin"};
        tbl[8]  = '{F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7dm2"};
        tbl[9]  = '{F_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, "multu_carry"};
        tbl[10] = '{F_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult_m1m1"};
        tbl[11] = '{F_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, "divu_max16"};

        ops[0] = F_MULT; ops[1] = F_MULTU; ops[2] = F_DIV; ops[3] = F_DIVU;

        // Reset
        rst = 1'b1; rs_data = '0; rt_data = '0;
        nop();
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_stall", stall, 0);
        check("reset_mf", mf_data, 0);

        // Directed table
        foreach (tbl[i]) begin
            do_op(tbl[i].f, tbl[i].a, tbl[i].b, cyc);
            check({tbl[i].name, "_busy_cycles"}, cyc, 33);
            check({tbl[i].name, "_hi"}, hi, tbl[i].hi);
            check({tbl[i].name, "_lo"}, lo, tbl[i].lo);
        end

        // MULT then MFLO held by stall
        opcode = 6'h00; func = F_MULT; rs_data = 32'hFFFF_FFFD; rt_data = 32'd7; flush = 1'b0;
        tick();
        func = F_MFLO;
        #1;
        cyc = 0;
        while (stall && cyc < 100) begin
            cyc++;
            tick();
        end
        check("mflo_stall_cycles", cyc, 33);
        check("mflo_data", mf_data, 32'hFFFF_FFEB);
        check("mflo_hi", hi, 32'hFFFF_FFFF);
        tick();
        nop();

        // MTHI then MFHI, no stall
        opcode = 6'h00; func = F_MTHI; rs_data = 32'h1234;
        #1;
        check("mthi_stall", stall, 0);
        tick();
        func = F_MFHI;
        #1;
        check("mfhi_stall", stall, 0);
        check("mfhi_data", mf_data, 32'h1234);
        nop();
        #1;
        check("nonhilo_mf_zero", mf_data, 0);

        // Flushed MTLO leaves LO alone
        opcode = 6'h00; func = F_MTLO; rs_data = 32'hDEAD_BEEF; flush = 1'b1;
        tick();
        nop();
        check("flush_mtlo_lo", lo, 32'hFFFF_FFEB);

        // Independent op overlaps a busy multiply; flushed hilo op does not stall
        opcode = 6'h00; func = F_MULTU; rs_data = 32'd3; rt_data = 32'd5;
        tick();
        func = F_ADD;
        #1;
        check("add_during_busy_stall", stall, 0);
        check("add_during_busy_busy", busy, 1);
        func = F_MFHI; flush = 1'b1;
        #1;
        check("flushed_mfhi_stall", stall, 0);
        nop();
        wait_idle(cyc);
        check("overlap_lo", lo, 32'd15);
        check("overlap_hi", hi, 32'd0);

        // Flushed MULT never issues
        opcode = 6'h00; func = F_MULT; rs_data = 32'd9; rt_data = 32'd9; flush = 1'b1;
        tick();
        nop();
        check("flush_mult_busy", busy, 0);
        check("flush_mult_lo", lo, 32'd15);
        check("flush_mult_hi", hi, 32'd0);

        // Flush while busy is ignored
        opcode = 6'h00; func = F_DIVU; rs_data = 32'd100; rt_data = 32'd7;
        tick();
        nop();
        flush = 1'b1;
        tick(); tick();
        flush = 1'b0;
        wait_idle(cyc);
        check("flush_busy_lo", lo, 32'd14);
        check("flush_busy_hi", hi, 32'd2);

        // Reset mid-divide
        opcode = 6'h00; func = F_DIV; rs_data = 32'd1000; rt_data = 32'd3;
        tick();
        nop();
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_hi", hi, 0);
        check("rst_mid_lo", lo, 0);
        do_op(F_DIVU, 32'd100, 32'd7, cyc);
        check("post_rst_cycles", cyc, 33);
        check("post_rst_lo", lo, 32'd14);
        check("post_rst_hi", hi, 32'd2);

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [5:0]  f;
            logic [31:0] a, b;
            f = ops[$urandom_range(3)];
            a = pick();
            b = pick();
            exp = ref_model(f, a, b);
            do_op(f, a, b, cyc);
            if (cyc != 33 || hi !== exp[63:32] || lo !== exp[31:0])
                $display("  op func=%0h a=%0h b=%0h", f, a, b);
            check("rand_cycles", cyc, 33);
            check("rand_hi", hi, exp[63:32]);
            check("rand_lo", lo, exp[31:0]);
            opcode = 6'h00;
            func = ($urandom_range(1) == 0) ? F_MFHI : F_MFLO;
            #1;
            check("rand_mf", mf_data, (func == F_MFHI) ? exp[63:32] : exp[31:0]);
            tick();
            nop();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
